// File: rtl/reg_file_param.sv
// Parametrised register file: byte-strobed write port, NRD combinational read ports,
// optional hardwired zero register and write-to-read bypass, post-reset scrub engine.
module reg_file_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [XLEN/8-1:0]   wstrb,
  output logic                busy,
  output logic                wr_drop
);

  localparam int NB = XLEN / 8;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [0:0]      state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;
  logic [XLEN-1:0] wr_merged;

  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] new_val,
                                                 input logic [NB-1:0]   strb);
    logic [XLEN-1:0] res;
    res = old_val;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign busy      = (state == CLEAR);
  assign wr_en     = we && !busy && !rst && !((ZERO_REG != 0) && (wa == '0));
  assign wr_merged = byte_merge(regs[wa], wd, wstrb);

  // Control: FSM, scrub index and dropped-write flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= busy & we;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) state <= READY;
      end
    end
  end

  // Storage: scrub has priority; a reset edge leaves the array untouched
  always_ff @(posedge clk) begin
    if (!rst && (state == CLEAR)) regs[clr_idx] <= '0;
    else if (wr_en)               regs[wa]      <= wr_merged;
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NRD; i++) begin
      if (busy || rst || ((ZERO_REG != 0) && (ra[i*AW +: AW] == '0)))
        rd[i*XLEN +: XLEN] = '0;
      else if ((BYPASS != 0) && wr_en && (ra[i*AW +: AW] == wa))
        rd[i*XLEN +: XLEN] = wr_merged;
      else
        rd[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
    end
  end

endmodule
